// File: rtl/lsu_pkg.sv
// Shared funct3 codes, FSM encoding and request legality
// for the data-memory load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;
  localparam logic [2:0] F3_SB  = 3'd0;
  localparam logic [2:0] F3_SH  = 3'd1;
  localparam logic [2:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    MERGE_WR,
    RESP
  } lsu_state_t;

  function automatic logic req_legal(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic ok_f3;
    logic ok_al;
    if (we)
      ok_f3 = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    else
      ok_f3 = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW)
           || (f3 == F3_LBU) || (f3 == F3_LHU);
    if (f3[1:0] == 2'd1)
      ok_al = !a[0];
    else if (f3[1:0] == 2'd2)
      ok_al = (a == 2'b00);
    else
      ok_al = 1'b1;
    return ok_f3 && ok_al;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane extract/extend for loads and lane merge for
// sub-word stores, both on a single 32-bit memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(word >> {lane, 3'b000});
    h = 16'(word >> {lane[1], 4'b0000});
    case (funct3)
      F3_LB:   load_data = {{24{b[7]}}, b};
      F3_LH:   load_data = {{16{h[15]}}, h};
      F3_LBU:  load_data = {24'd0, b};
      F3_LHU:  load_data = {16'd0, h};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merge_data = word;
    case (funct3[1:0])
      2'd0:    merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      2'd1:    merge_data[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time, RMW for
// sub-word stores, extended loads, error on illegal requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 10,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t      state;
  logic            we_q;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] word_q;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merge_data;
  logic [XLEN-1:0] align_word;
  logic            sw_access;

  // ACCESS sees the live memory word, MERGE_WR the captured one
  assign align_word = (state == ACCESS) ? mem_rdata : word_q;

  lsu_align u_align (
    .funct3     (f3_q),
    .lane       (lane_q),
    .word       (align_word),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_ready = (state == IDLE);
  assign sw_access = (state == ACCESS) && we_q && (f3_q == F3_SW);
  assign mem_we    = !rst && (sw_access || state == MERGE_WR);

  always_comb begin
    mem_wdata = '0;
    if (sw_access)
      mem_wdata = wdata_q;
    else if (state == MERGE_WR)
      mem_wdata = merge_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      f3_q      <= '0;
      lane_q    <= '0;
      wdata_q   <= '0;
      word_q    <= '0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            f3_q    <= req_funct3;
            lane_q  <= req_addr[1:0];
            wdata_q <= req_wdata;
            if (req_legal(req_we, req_funct3, req_addr[1:0])) begin
              mem_addr <= req_addr[MEM_AW+1:2];
              state    <= ACCESS;
            end else begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= RESP;
            end
          end
        end
        ACCESS: begin
          if (!we_q) begin
            rsp_rdata <= load_data;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (f3_q == F3_SW) begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            word_q <= mem_rdata;
            state  <= MERGE_WR;
          end
        end
        MERGE_WR: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised and directed checks of load_store_unit against
// a byte-addressed reference memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [1024];
  logic [7:0]  rb  [4096];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic set_word(input int idx, input logic [31:0] v);
    mem[idx] = v;
    for (int k = 0; k < 4; k++) rb[idx*4+k] = v[8*k +: 8];
  endtask

  // Reference: byte memory, access size from funct3, plain arithmetic
  task automatic model(input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit err,
                       output int lat, output int nwr);
    int sz;
    int base;
    logic [31:0] v;
    logic [31:0] t;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    err = (f3 == 3) || (f3 >= 6) || (we && f3 > 2) || ((a % sz) != 0);
    base = int'(a[11:0]);
    rd = 0; lat = 1; nwr = 0;
    if (err) return;
    if (!we) begin
      v = 0;
      for (int i = 0; i < sz; i++) v = v | (32'(rb[base+i]) << (8*i));
      if (!f3[2] && sz < 4 && ((v >> (8*sz-1)) & 1) == 1)
        v = v | (32'hFFFF_FFFF << (8*sz));
      rd = v; lat = 2;
    end else begin
      for (int i = 0; i < sz; i++) begin
        t = wd >> (8*i);
        rb[base+i] = t[7:0];
      end
      lat = (sz == 4) ? 2 : 3;
      nwr = 1;
    end
  endtask

  task automatic xact(input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit err,
                      output int lat, output int nwr,
                      output logic [31:0] lastwd);
    int n;
    rd = '0; err = 0; lat = -1; nwr = 0; lastwd = '0;
    @(negedge clk);
    req_valid = 1; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      req_valid = 0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 0;
    req_we = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr = $urandom;
    req_wdata = $urandom;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (mem_we) begin
        nwr++;
        lastwd = mem_wdata;
      end
      if (rsp_valid) begin
        rd = rsp_rdata; err = rsp_err; lat = c;
        return;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_we} !== 4'b1000) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 1000",
               {req_ready, rsp_valid, rsp_err, mem_we});
    end
    checks++;
    if ({rsp_rdata, mem_wdata, mem_addr} !== '0) begin
      fails++;
      $display("FAIL reset_data: got %h %h %h expected 0",
               rsp_rdata, mem_wdata, mem_addr);
    end
    rst = 0;
  endtask

  task automatic test_loads;
    logic [31:0] ad [5] = '{32'h1C, 32'h29, 32'h2B, 32'h2A, 32'h2A};
    logic [2:0]  f3 [5] = '{3'd2, 3'd0, 3'd0, 3'd5, 3'd1};
    logic [31:0] ex [5] = '{32'h0000_0020, 32'h0000_007F, 32'hFFFF_FF80,
                            32'h0000_80FF, 32'hFFFF_80FF};
    logic [31:0] rd, mrd, lw;
    bit err, merr;
    int lat, nwr, mlat, mnwr;
    set_word(7, 32'h0000_0020);
    set_word(10, 32'h80FF_7F02);
    for (int i = 0; i < 5; i++) begin
      model(0, f3[i], ad[i], 0, mrd, merr, mlat, mnwr);
      xact(0, f3[i], ad[i], $urandom, rd, err, lat, nwr, lw);
      checks++;
      if (rd !== ex[i] || err !== 0 || lat != 2 || nwr != 0) begin
        fails++;
        $display("FAIL load_%0d: got rd=%h err=%0d lat=%0d wr=%0d expected rd=%h err=0 lat=2 wr=0",
                 i, rd, err, lat, nwr, ex[i]);
      end
    end
  endtask

  task automatic test_sub_store;
    logic [31:0] rd, mrd, lw;
    bit err, merr;
    int lat, nwr, mlat, mnwr;
    set_word(4, 32'h1122_3344);
    model(1, 3'd0, 32'h12, 32'hAB, mrd, merr, mlat, mnwr);
    xact(1, 3'd0, 32'h12, 32'hAB, rd, err, lat, nwr, lw);
    checks++;
    if (nwr != 1 || lw !== 32'h11AB_3344 || lat != 3 || err !== 0) begin
      fails++;
      $display("FAIL sb_rmw: got wr=%0d wdata=%h lat=%0d err=%0d expected wr=1 wdata=11ab3344 lat=3 err=0",
               nwr, lw, lat, err);
    end
    model(0, 3'd2, 32'h10, 0, mrd, merr, mlat, mnwr);
    xact(0, 3'd2, 32'h10, 0, rd, err, lat, nwr, lw);
    checks++;
    if (rd !== 32'h11AB_3344 || lat != 2) begin
      fails++;
      $display("FAIL sb_readback: got %h lat=%0d expected 11ab3344 lat=2", rd, lat);
    end
  endtask

  task automatic test_errors;
    logic        we [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  f3 [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
    logic [31:0] ad [4] = '{32'h11, 32'h1E, 32'h20, 32'h20};
    logic [31:0] rd, lw;
    bit err;
    int lat, nwr;
    for (int i = 0; i < 4; i++) begin
      xact(we[i], f3[i], ad[i], 32'hFFFF_FFFF, rd, err, lat, nwr, lw);
      checks++;
      if (err !== 1 || rd !== 0 || lat != 1 || nwr != 0) begin
        fails++;
        $display("FAIL err_%0d: got err=%0d rd=%h lat=%0d wr=%0d expected err=1 rd=0 lat=1 wr=0",
                 i, err, rd, lat, nwr);
      end
    end
  endtask

  task automatic test_rmw_reset;
    bit seen_rsp;
    set_word(4, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd1;
    req_addr = 32'h10; req_wdata = 32'h5555;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (mem_we !== 0) begin
      fails++;
      $display("FAIL rst_gate_we: got %b expected 0", mem_we);
    end
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1 || rsp_valid !== 0) begin
      fails++;
      $display("FAIL rst_idle: got ready=%b rsp=%b expected ready=1 rsp=0",
               req_ready, rsp_valid);
    end
    seen_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1;
    end
    checks++;
    if (mem[4] !== 32'h1122_3344 || seen_rsp) begin
      fails++;
      $display("FAIL rst_no_write: got word=%h rsp=%0d expected word=11223344 rsp=0",
               mem[4], seen_rsp);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] mrd;
    bit merr;
    int mlat, mnwr, c1, c2;
    logic [31:0] rd2;
    model(1, 3'd2, 32'h0, 32'hDEAD_BEEF, mrd, merr, mlat, mnwr);
    model(0, 3'd2, 32'h0, 0, mrd, merr, mlat, mnwr);
    @(negedge clk);
    req_valid = 1; req_we = 1; req_funct3 = 3'd2;
    req_addr = 32'h0; req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_we = 0;
    req_wdata = 32'h0;
    c1 = -1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c1 = c;
        break;
      end
    end
    @(negedge clk);
    checks++;
    if (c1 != 2 || req_ready !== 1) begin
      fails++;
      $display("FAIL b2b_first: got lat=%0d ready=%b expected lat=2 ready=1", c1, req_ready);
    end
    @(posedge clk);
    #1 req_valid = 0;
    c2 = -1;
    rd2 = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c2 = c;
        rd2 = rsp_rdata;
        break;
      end
    end
    checks++;
    if (c2 != 2 || rd2 !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL b2b_load: got lat=%0d rd=%h expected lat=2 rd=deadbeef", c2, rd2);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, wd, rd, mrd, lw;
    logic [2:0] f3;
    bit we, err, merr;
    int lat, nwr, mlat, mnwr, bad;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      wd = $urandom;
      model(we, f3, a, wd, mrd, merr, mlat, mnwr);
      xact(we, f3, a, wd, rd, err, lat, nwr, lw);
      checks++;
      if (rd !== mrd || err !== merr || lat != mlat || nwr != mnwr) begin
        fails++;
        $display("FAIL rand_%0d we=%0d f3=%0d a=%h: got rd=%h err=%0d lat=%0d wr=%0d expected rd=%h err=%0d lat=%0d wr=%0d",
                 i, we, f3, a, rd, err, lat, nwr, mrd, merr, mlat, mnwr);
      end
    end
    bad = 0;
    for (int w = 0; w < 1024; w++)
      if (mem[w] !== {rb[4*w+3], rb[4*w+2], rb[4*w+1], rb[4*w]}) bad++;
    checks++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mem_final: got %0d differing words expected 0", bad);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) set_word(i, $urandom);
    test_reset();
    test_loads();
    test_errors();
    test_rmw_reset();
    test_sub_store();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the single-cycle core's data-memory interface.
- Accepts one load/store request at a time from the execute stage and decodes RV32I funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW).
- Drives the word-wide data memory: WE/WD/A out, RD in. The memory's RD is combinational; its write takes effect at posedge when WE=1.
- Sub-word stores are read-modify-write. Load results are sign- or zero-extended, and misaligned or illegal requests get an error response.

Parameters:
- MEM_AW, 10, word-address width driven on mem_addr (1024-word memory).
- XLEN, 32, data/address width.

Ports:
- clk  in  1  clock; rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept (high only in IDLE).
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RV32I width/sign code.
- req_addr  in  XLEN  byte address.
- req_wdata  in  XLEN  store data (low bits used for SB/SH).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal funct3; valid with rsp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  MEM_AW  word index = req_addr[MEM_AW+1:2]; upper address bits ignored (wrap).
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, combinational.

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE on the first clk edge with rst=1.
  - Outputs after reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is gated by !rst combinationally, so no write occurs in any cycle with rst=1, including mid-RMW.
- Handshake: a request is accepted on an edge with req_valid && req_ready.
  - All request fields are registered at acceptance; later changes on req_* are ignored until the next IDLE.
  - req_ready=0 in every state other than IDLE.
- Legality check (at acceptance):
  - H/HU need addr[0]=0; W needs addr[1:0]=0.
  - funct3 3,6,7 are illegal; for stores, only 0, 1 and 2 are legal.
  - Illegal or misaligned → go to RESP with rsp_err=1 and no memory access.
- FSM states: IDLE, ACCESS, MERGE_WR, RESP.
- IDLE: accept the request → ACCESS (legal) or RESP (error).
- ACCESS: mem_addr is driven from the registered address.
  - Load: capture mem_rdata → RESP.
    - Byte lane = addr[1:0], half lane = addr[1].
    - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the word as-is.
  - SW: mem_we=1, mem_wdata=wdata → RESP.
  - SB/SH: capture mem_rdata → MERGE_WR.
- MERGE_WR: mem_we=1, mem_addr unchanged.
  - mem_wdata = captured word with the selected byte/half lane replaced by wdata[7:0] or wdata[15:0]; other lanes preserved → RESP.
- RESP: rsp_valid=1 for exactly one cycle → IDLE.
  - rsp_rdata and rsp_err are held stable during RESP and cleared to 0 on return to IDLE.
- Latency, in cycles after the accept edge until rsp_valid is high:
  - LW/LB/LH/LBU/LHU/SW: 2.
  - SB/SH: 3.
  - Error: 1.
- Back-to-back throughput: the next request is accepted at the edge ending RESP+IDLE, i.e. req_ready rises the cycle after rsp_valid.
- A store followed by a load to the same word returns the new data; the write has completed before the load's ACCESS.
- Outside ACCESS and MERGE_WR: mem_we=0, and mem_addr holds its last value.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_LB=0, F3_LH=1, F3_LW=2, F3_LBU=4, F3_LHU=5, F3_SB=0, F3_SH=1, F3_SW=2.
  - FSM state encoding.
- One sub-module, lsu_align: combinational lane extract/extend for loads and lane merge for stores, driven by funct3, addr[1:0], word and wdata. Shared by ACCESS and MERGE_WR.
- FSM and registers stay in load_store_unit.

Test Plan:
- Memory word 7 = 0x00000020. LW addr 0x1C → rsp_valid 2 cycles after accept, rsp_rdata=0x00000020, rsp_err=0, mem_we never high.
- Word 10 = 0x80FF7F02. LB addr 0x29 → 0xFFFFFF80... correction: byte 1 = 0x7F → 0x0000007F. LB 0x2B → 0xFFFFFF80. LHU 0x2A → 0x000080FF. LH 0x2A → 0xFFFF80FF.
- Word 4 = 0x11223344. SB addr 0x12 wdata 0xAB → mem_we high exactly one cycle (MERGE_WR) with mem_wdata=0x11AB3344; rsp 3 cycles after accept. A following LW 0x10 returns 0x11AB3344.
- SH addr 0x11 → rsp_err=1, rsp_rdata=0 one cycle after accept, mem_we never asserted. LW addr 0x1E and funct3=3 also give rsp_err=1.
- SH to word 4 with rst asserted during MERGE_WR → no write (word stays 0x11223344), LSU in IDLE with req_ready=1 after the reset edge, no rsp_valid.
- Back-to-back SW 0x0 wdata 0xDEADBEEF then LW 0x0, req_valid held high → second request accepted the cycle after the first rsp_valid; returns 0xDEADBEEF.
